// File: rtl/commit_trace_serializer.sv
// Commit trace serializer: compacts up to RETIRE_W retiring instructions per
// cycle into a FIFO and emits one sequence-tagged record per accepted handshake.
module commit_trace_serializer #(
    parameter int unsigned RETIRE_W = 6,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ADDR_W   = 40
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [RETIRE_W-1:0]        commit_valid,
    input  logic [RETIRE_W*5-1:0]      commit_ldst,
    input  logic [RETIRE_W*3-1:0]      commit_rtype,
    input  logic [RETIRE_W*ADDR_W-1:0] commit_pc,
    input  logic [RETIRE_W*32-1:0]     commit_inst,
    input  logic [RETIRE_W*XLEN-1:0]   commit_wdata,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_ldst,
    output logic [2:0]                 out_rtype,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_wdata,
    output logic [63:0]                out_seq,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow,
    output logic [31:0]                drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(RETIRE_W + 1);

    typedef struct packed {
        logic [4:0]        ldst;
        logic [2:0]        rtype;
        logic [ADDR_W-1:0] pc;
        logic [31:0]       inst;
        logic [XLEN-1:0]   wdata;
        logic [63:0]       seq;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             comp [RETIRE_W];
    rec_t             head_rec_q;
    rec_t             head_rec_n;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] head_n;
    logic [PTR_W-1:0] tail_n;
    logic [OCC_W-1:0] occ_rem;
    logic [OCC_W-1:0] occ_n;
    logic [CNT_W-1:0] slot_off;
    logic [CNT_W-1:0] k;
    logic [63:0]      seq_q;
    logic [63:0]      seq_n;
    logic [32:0]      drop_sum;
    logic             pop;
    logic             accept;
    logic             drop;

    // Compact valid slots into consecutive entries, tagging each with its sequence number
    always_comb begin
        comp     = '{default: '0};
        slot_off = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (commit_valid[i]) begin
                comp[slot_off].ldst  = commit_ldst[i*5 +: 5];
                comp[slot_off].rtype = commit_rtype[i*3 +: 3];
                comp[slot_off].pc    = commit_pc[i*ADDR_W +: ADDR_W];
                comp[slot_off].inst  = commit_inst[i*32 +: 32];
                comp[slot_off].wdata = commit_wdata[i*XLEN +: XLEN];
                comp[slot_off].seq   = seq_q + 64'(slot_off);
                slot_off             = slot_off + CNT_W'(1);
            end
        end
        k = slot_off;
    end

    // Push/pop/drop decisions and next-state pointers, counters and head record
    always_comb begin
        pop      = out_valid && out_ready;
        accept   = in_ready && (commit_valid != '0);
        drop     = !in_ready && (commit_valid != '0);
        head_n   = head_q + PTR_W'(pop);
        tail_n   = accept ? tail_q + PTR_W'(k) : tail_q;
        occ_rem  = occupancy - OCC_W'(pop);
        occ_n    = accept ? occ_rem + OCC_W'(k) : occ_rem;
        seq_n    = accept ? seq_q + 64'(k) : seq_q;
        drop_sum = {1'b0, drop_count} + 33'(k);
        // When the FIFO is empty after the pop, the new head is the first record pushed now
        head_rec_n = (occ_rem == '0) ? comp[0] : mem[head_n];
    end

    // Control state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            occupancy  <= '0;
            seq_q      <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
            head_rec_q <= '0;
        end else begin
            head_q     <= head_n;
            tail_q     <= tail_n;
            occupancy  <= occ_n;
            seq_q      <= seq_n;
            out_valid  <= (occ_n != '0);
            in_ready   <= (OCC_W'(DEPTH) - occ_n) >= OCC_W'(RETIRE_W);
            overflow   <= overflow | drop;
            head_rec_q <= head_rec_n;
            if (drop) begin
                drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            end
        end
    end

    // Record storage; contents are don't-care until written so no reset
    always_ff @(posedge clock) begin
        for (int j = 0; j < RETIRE_W; j++) begin
            if (accept && (CNT_W'(j) < k)) begin
                mem[tail_q + PTR_W'(j)] <= comp[j];
            end
        end
    end

    assign out_ldst  = head_rec_q.ldst;
    assign out_rtype = head_rec_q.rtype;
    assign out_pc    = head_rec_q.pc;
    assign out_inst  = head_rec_q.inst;
    assign out_wdata = head_rec_q.wdata;
    assign out_seq   = head_rec_q.seq;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Randomized bench for commit_trace_serializer with a queue-based reference model.
module tb_commit_trace_serializer;

    localparam int unsigned RW    = 6;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned AW    = 40;

    logic                 clock;
    logic                 reset;
    logic [RW-1:0]        commit_valid;
    logic [RW*5-1:0]      commit_ldst;
    logic [RW*3-1:0]      commit_rtype;
    logic [RW*AW-1:0]     commit_pc;
    logic [RW*32-1:0]     commit_inst;
    logic [RW*XLEN-1:0]   commit_wdata;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [4:0]           out_ldst;
    logic [2:0]           out_rtype;
    logic [AW-1:0]        out_pc;
    logic [31:0]          out_inst;
    logic [XLEN-1:0]      out_wdata;
    logic [63:0]          out_seq;
    logic [$clog2(DEPTH):0] occupancy;
    logic                 overflow;
    logic [31:0]          drop_count;

    commit_trace_serializer #(
        .RETIRE_W(RW), .DEPTH(DEPTH), .XLEN(XLEN), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_ldst(commit_ldst),
        .commit_rtype(commit_rtype), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_wdata(commit_wdata),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_ldst(out_ldst), .out_rtype(out_rtype), .out_pc(out_pc),
        .out_inst(out_inst), .out_wdata(out_wdata), .out_seq(out_seq),
        .occupancy(occupancy), .overflow(overflow), .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]      ldst;
        logic [2:0]      rtype;
        logic [AW-1:0]   pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] wdata;
        logic [63:0]     seq;
    } mrec_t;

    mrec_t       q[$];
    mrec_t       m_r;
    logic [63:0] m_seq;
    longint      m_drop;
    bit          m_ovf;
    bit          m_inr;
    int          m_sz;
    bit          chk_en;
    int          errors;
    int          checks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of whole records updated once per rising edge
    always @(posedge clock) begin
        if (reset) begin
            m_sz  = q.size();
            m_inr = (DEPTH - m_sz) >= RW;
            if (m_sz != 0 && out_ready) void'(q.pop_front());
            if (commit_valid != '0) begin
                if (m_inr) begin
                    for (int i = 0; i < RW; i++) begin
                        if (commit_valid[i]) begin
                            m_r.ldst  = commit_ldst[i*5 +: 5];
                            m_r.rtype = commit_rtype[i*3 +: 3];
                            m_r.pc    = commit_pc[i*AW +: AW];
                            m_r.inst  = commit_inst[i*32 +: 32];
                            m_r.wdata = commit_wdata[i*XLEN +: XLEN];
                            m_r.seq   = m_seq;
                            m_seq     = m_seq + 1;
                            q.push_back(m_r);
                        end
                    end
                end else begin
                    m_drop = m_drop + $countones(commit_valid);
                    if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clock) begin
        if (chk_en) begin
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= RW));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            if (q.size() != 0) begin
                chk("out_seq", out_seq, q[0].seq);
                chk("out_pc", 64'(out_pc), 64'(q[0].pc));
                chk("out_ldst", 64'(out_ldst), 64'(q[0].ldst));
                chk("out_rtype", 64'(out_rtype), 64'(q[0].rtype));
                chk("out_inst", 64'(out_inst), 64'(q[0].inst));
                chk("out_wdata", 64'(out_wdata), 64'(q[0].wdata));
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_slots();
        for (int i = 0; i < RW; i++) begin
            commit_ldst[i*5 +: 5]     = 5'($urandom);
            commit_rtype[i*3 +: 3]    = 3'($urandom);
            commit_pc[i*AW +: AW]     = {8'($urandom), 32'($urandom)};
            commit_inst[i*32 +: 32]   = $urandom;
            commit_wdata[i*XLEN +: XLEN] = {$urandom, $urandom};
        end
    endtask

    // Assert reset between edges, check the immediate effect, then release
    task automatic apply_reset();
        commit_valid = '0;
        reset = 1'b0;
        q.delete();
        m_seq  = '0;
        m_drop = 0;
        m_ovf  = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_out_seq", out_seq, 64'd0);
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rnd;
        errors = 0;
        checks = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        out_ready = 1'b0;
        commit_valid = '0;
        commit_ldst = '0;
        commit_rtype = '0;
        commit_pc = '0;
        commit_inst = '0;
        commit_wdata = '0;
        m_seq = '0;
        m_drop = 0;
        m_ovf = 1'b0;
        #2;
        apply_reset();
        chk_en = 1'b1;

        // Three contiguous commits drain one per cycle, one cycle after acceptance
        out_ready = 1'b1;
        rand_slots();
        commit_pc[0*AW +: AW] = 40'h100;
        commit_pc[1*AW +: AW] = 40'h104;
        commit_pc[2*AW +: AW] = 40'h108;
        commit_valid = 6'b000111;
        cycle();
        commit_valid = '0;
        chk("d1_valid0", 64'(out_valid), 64'd1);
        chk("d1_pc0", 64'(out_pc), 64'h100);
        chk("d1_seq0", out_seq, 64'd0);
        cycle();
        chk("d1_pc1", 64'(out_pc), 64'h104);
        chk("d1_seq1", out_seq, 64'd1);
        cycle();
        chk("d1_pc2", 64'(out_pc), 64'h108);
        chk("d1_seq2", out_seq, 64'd2);
        cycle();
        chk("d1_empty", 64'(out_valid), 64'd0);

        // Sparse pattern compacts slots 0,3,5
        apply_reset();
        out_ready = 1'b0;
        rand_slots();
        for (int i = 0; i < RW; i++) commit_pc[i*AW +: AW] = 40'h1000 + 40'(i);
        commit_valid = 6'b101001;
        cycle();
        commit_valid = '0;
        chk("d2_occ", 64'(occupancy), 64'd3);
        chk("d2_pc0", 64'(out_pc), 64'h1000);
        chk("d2_seq0", out_seq, 64'd0);
        out_ready = 1'b1;
        cycle();
        chk("d2_pc1", 64'(out_pc), 64'h1003);
        chk("d2_seq1", out_seq, 64'd1);
        cycle();
        chk("d2_pc2", 64'(out_pc), 64'h1005);
        chk("d2_seq2", out_seq, 64'd2);
        cycle();
        chk("d2_empty", 64'(out_valid), 64'd0);

        // Fill to 12, drop a full bundle, then resume without a sequence gap
        apply_reset();
        out_ready = 1'b0;
        commit_valid = '1;
        rand_slots();
        cycle();
        rand_slots();
        cycle();
        chk("d3_occ12", 64'(occupancy), 64'd12);
        chk("d3_not_ready", 64'(in_ready), 64'd0);
        rand_slots();
        cycle();
        commit_valid = '0;
        chk("d3_drop6", 64'(drop_count), 64'd6);
        chk("d3_ovf", 64'(overflow), 64'd1);
        chk("d3_occ_kept", 64'(occupancy), 64'd12);
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("d3_occ10", 64'(occupancy), 64'd10);
        chk("d3_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        rand_slots();
        commit_pc[0*AW +: AW] = 40'hABC;
        commit_valid = 6'b000001;
        cycle();
        commit_valid = '0;
        chk("d3_occ11", 64'(occupancy), 64'd11);
        out_ready = 1'b1;
        repeat (10) cycle();
        chk("d3_resume_seq", out_seq, 64'd12);
        chk("d3_resume_pc", 64'(out_pc), 64'hABC);
        cycle();

        // Reset clears the sticky overflow; then single-slot streaming wraps pointers
        apply_reset();
        out_ready = 1'b1;
        commit_valid = 6'b000001;
        for (int n = 0; n < 40; n++) begin
            rand_slots();
            cycle();
            chk("d4_occ_le1", 64'(occupancy <= 1), 64'd1);
        end
        commit_valid = '0;
        chk("d4_last_seq", out_seq, 64'd39);
        cycle();

        // Reset with seven buffered records, then sequence restarts at zero
        out_ready = 1'b0;
        commit_valid = '1;
        rand_slots();
        cycle();
        commit_valid = 6'b000001;
        rand_slots();
        cycle();
        commit_valid = '0;
        chk("d5_occ7", 64'(occupancy), 64'd7);
        apply_reset();
        rand_slots();
        commit_valid = 6'b000100;
        cycle();
        commit_valid = '0;
        chk("d5_valid", 64'(out_valid), 64'd1);
        chk("d5_seq0", out_seq, 64'd0);
        cycle();

        // Long random run with alternating traffic phases
        for (int n = 0; n < 10000; n++) begin
            rand_slots();
            rnd = $urandom;
            if (((n / 1000) % 2) == 0)
                commit_valid = ($urandom_range(0, 2) == 0) ? rnd[RW-1:0] : '0;
            else
                commit_valid = ($urandom_range(0, 4) == 0) ? rnd[RW-1:0] : '0;
            out_ready = (((n / 500) % 2) == 0) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 3) == 0);
            cycle();
        end
        commit_valid = '0;
        out_ready = 1'b1;
        repeat (20) cycle();
        chk("d6_drained", 64'(occupancy), 64'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/commit_trace_serializer.md
COMMIT_TRACE_SERIALIZER -- requirements
Module: commit_trace_serializer

Interface
REQ-001 Parameter RETIRE_W, default 6: commit slots per cycle.
REQ-002 Parameter DEPTH, default 16: FIFO entries; power of two, at least 2*RETIRE_W.
REQ-003 Parameter XLEN, default 64: integer writeback data width.
REQ-004 Parameter ADDR_W, default 40: PC width.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low; asserted when 0.
REQ-007 commit_valid  in  RETIRE_W  per-slot commit valid; slot 0 is oldest.
REQ-008 commit_ldst  in  RETIRE_W*5  per-slot logical destination register.
REQ-009 commit_rtype  in  RETIRE_W*3  per-slot destination register type.
REQ-010 commit_pc  in  RETIRE_W*ADDR_W  per-slot PC.
REQ-011 commit_inst  in  RETIRE_W*32  per-slot instruction word.
REQ-012 commit_wdata  in  RETIRE_W*XLEN  per-slot writeback data.
REQ-013 in_ready  out  1  FIFO can accept a full bundle this cycle.
REQ-014 out_valid  out  1  record available at the output.
REQ-015 out_ready  in  1  consumer accepts the record.
REQ-016 out_ldst / out_rtype / out_pc / out_inst / out_wdata  out  5 / 3 / ADDR_W / 32 / XLEN  fields of the head record.
REQ-017 out_seq  out  64  retire sequence number of the head record.
REQ-018 occupancy  out  log2(DEPTH)+1  number of stored records.
REQ-019 overflow  out  1  sticky: at least one commit has been dropped.
REQ-020 drop_count  out  32  total commits dropped.

Function
REQ-021 The block shall set in_ready = 1 when (DEPTH - occupancy) >= RETIRE_W, computed from registered occupancy only.
REQ-022 When in_ready = 1, all set commit_valid slots in one cycle shall be written to consecutive FIFO entries at the tail, in ascending slot order, with gaps compacted out.
REQ-023 Non-contiguous valid patterns (e.g. 6'b101001) shall be accepted and compacted identically to contiguous ones.
REQ-024 Each accepted record shall be tagged with a 64-bit sequence number that starts at 0 after reset and increments by one per accepted commit, in acceptance order.
REQ-025 out_valid shall equal (occupancy != 0).
REQ-026 The out_* fields shall come from registered FIFO storage; a record accepted in cycle N shall first be visible at the output in cycle N+1.
REQ-027 A pop shall occur when out_valid and out_ready are both 1.
REQ-028 The head fields shall hold stable while out_valid = 1 and out_ready = 0.
REQ-029 On a simultaneous push of k records and a pop, the next occupancy shall be occupancy + k - 1.
REQ-030 Head and tail pointers shall wrap modulo DEPTH; a push that spans the wrap shall split correctly.
REQ-031 When commit_valid != 0 and in_ready = 0, the entire bundle shall be dropped, no partial bundle shall be accepted, and the sequence counter shall not advance.
REQ-032 On such a drop, drop_count shall increase by popcount(commit_valid), saturating at 2^32-1.
REQ-033 On such a drop, overflow shall be set and shall remain set until reset.
REQ-034 commit_valid = 0 shall change no state other than a pop.

Reset
REQ-035 Reset assertion shall immediately clear the pointers, occupancy, out_seq, the sequence counter, overflow and drop_count, and force out_valid = 0 and in_ready = 1, without waiting for a clock edge.
REQ-036 Reset asserted mid-operation shall discard all buffered records, and the first record accepted after reset shall carry sequence number 0.
REQ-037 FIFO data storage shall need no reset; out_* data fields are don't-care while out_valid = 0.
REQ-038 Reset deassertion shall be synchronized externally; the block shall accept commits from the first rising edge after deassertion.

Verification
REQ-039 Reset, then commit_valid=6'b000111 with pc 0x100/0x104/0x108, out_ready=1 -> three records emitted on consecutive cycles starting one cycle later, seq 0,1,2, pc in order.
REQ-040 commit_valid=6'b101001, out_ready=0 -> occupancy=3; stored records are slots 0, 3, 5 in that order with seq 0,1,2.
REQ-041 Hold out_ready=0 and push full bundles -> in_ready drops when occupancy=12 (DEPTH 16); the next full bundle is dropped, drop_count=6, overflow=1, and a later accepted record continues seq with no gap.
REQ-042 Sustained single-slot commits with out_ready=1 for 40 cycles -> occupancy never exceeds 1 and the pointers wrap; seq 0..39 emitted in order.
REQ-043 Assert reset with occupancy=7 -> immediately out_valid=0, occupancy=0, overflow=0; the first post-reset record has seq 0.
REQ-044 Random valid patterns and random out_ready for 10k cycles against a scoreboard model -> every accepted commit is emitted exactly once, in order, with correct fields.
